ctrl_phase_sequencer: RTL

// - Downstream consumer of the controller's run counter (state_count / end_signal) in the NxN systolic array.
// - Decodes each counted cycle into LOAD (weights), FEED (activations) and DRAIN (outputs) phases.
// - Produces registered row enables and addresses for the weight, activation and output buffers.
// - Flags the end of a run with a one-cycle done pulse.

---
 rtl/ctrl_phase_sequencer_if.sv | 33 +++
 rtl/ctrl_phase_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ctrl_phase_sequencer_if.sv
// Bundle between the run counter/controller and the phase sequencer of the systolic array.
// The master drives the counter view; the slave (the sequencer) drives phase, strobes and row addresses.
interface ctrl_phase_sequencer_if #(
   parameter int CNT_W  = 9,
   parameter int ADDR_W = 7
);
   logic              start;
   logic [CNT_W-1:0]  state_count;
   logic              end_signal;
   logic [2:0]        phase;
   logic              busy;
   logic              w_load_en;
   logic [ADDR_W-1:0] w_row_addr;
   logic              act_feed_en;
   logic [ADDR_W-1:0] act_row_addr;
   logic              acc_clear;
   logic              drain_en;
   logic [ADDR_W-1:0] drain_row;
   logic              done;
   logic              seq_err;

   modport master (
      output start, state_count, end_signal,
      input  phase, busy, w_load_en, w_row_addr, act_feed_en, act_row_addr,
             acc_clear, drain_en, drain_row, done, seq_err
   );

   modport slave (
      input  start, state_count, end_signal,
      output phase, busy, w_load_en, w_row_addr, act_feed_en, act_row_addr,
             acc_clear, drain_en, drain_row, done, seq_err
   );
endinterface

// File: rtl/ctrl_phase_sequencer.sv
// Decodes the run counter into LOAD/FEED/DRAIN phases with registered strobes, row addresses and a done pulse.
// Define CTRL_SEQ_CHECK_EN to compile the sticky counter-sequence checker behind seq_err.
module ctrl_phase_sequencer #(
   parameter int N      = 128,
   parameter int CNT_W  = 9,
   parameter int ADDR_W = 7
) (
   input logic clk,
   input logic rst,
   ctrl_phase_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_LOAD  = 3'd1,
      PH_FEED  = 3'd2,
      PH_DRAIN = 3'd3,
      PH_DONE  = 3'd4
   } phase_t;

   localparam logic [CNT_W-1:0] L_N  = CNT_W'(N);
   localparam logic [CNT_W-1:0] L_2N = CNT_W'(2 * N);
   localparam logic [CNT_W-1:0] L_3N = CNT_W'(3 * N);

   phase_t            r_phase, w_phase_next;
   logic              r_end_d;
   logic              r_busy, w_busy_next;
   logic              r_load_en, w_load_en_next;
   logic [ADDR_W-1:0] r_load_addr, w_load_addr_next;
   logic              r_feed_en, w_feed_en_next;
   logic [ADDR_W-1:0] r_feed_addr, w_feed_addr_next;
   logic              r_acc_clear, w_acc_clear_next;
   logic              r_drain_en, w_drain_en_next;
   logic [ADDR_W-1:0] r_drain_addr, w_drain_addr_next;
   logic              r_done, w_done_next;

   logic              w_run, w_end_rise;
   logic [CNT_W-1:0]  w_sc, w_feed_off, w_drain_off;

   assign w_sc        = bus.state_count;
   assign w_run       = bus.start & ~bus.end_signal;
   assign w_end_rise  = bus.end_signal & ~r_end_d;
   assign w_feed_off  = w_sc - L_N;
   assign w_drain_off = w_sc - L_2N;

   // Everything holds by default so a pause or an illegal count freezes phase and addresses.
   always_comb begin
      w_phase_next      = r_phase;
      w_load_en_next    = 1'b0;
      w_load_addr_next  = r_load_addr;
      w_feed_en_next    = 1'b0;
      w_feed_addr_next  = r_feed_addr;
      w_acc_clear_next  = 1'b0;
      w_drain_en_next   = 1'b0;
      w_drain_addr_next = r_drain_addr;
      w_done_next       = 1'b0;

      if (w_end_rise) begin
         w_phase_next = PH_DONE;
         w_done_next  = 1'b1;
      end else if (r_phase == PH_DONE) begin
         if (!bus.end_signal && !bus.start)
            w_phase_next = PH_IDLE;
      end else if (w_run) begin
         if (w_sc < L_N) begin
            w_phase_next     = PH_LOAD;
            w_load_en_next   = 1'b1;
            w_load_addr_next = w_sc[ADDR_W-1:0];
         end else if (w_sc < L_2N) begin
            w_phase_next     = PH_FEED;
            w_feed_en_next   = 1'b1;
            w_feed_addr_next = w_feed_off[ADDR_W-1:0];
            w_acc_clear_next = (w_sc == L_N);
         end else if (w_sc < L_3N) begin
            w_phase_next      = PH_DRAIN;
            w_drain_en_next   = 1'b1;
            w_drain_addr_next = w_drain_off[ADDR_W-1:0];
         end
      end

      w_busy_next = (w_phase_next == PH_LOAD) || (w_phase_next == PH_FEED) ||
                    (w_phase_next == PH_DRAIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase      <= PH_IDLE;
         r_end_d      <= 1'b0;
         r_busy       <= 1'b0;
         r_load_en    <= 1'b0;
         r_load_addr  <= '0;
         r_feed_en    <= 1'b0;
         r_feed_addr  <= '0;
         r_acc_clear  <= 1'b0;
         r_drain_en   <= 1'b0;
         r_drain_addr <= '0;
         r_done       <= 1'b0;
      end else begin
         r_phase      <= w_phase_next;
         r_end_d      <= bus.end_signal;
         r_busy       <= w_busy_next;
         r_load_en    <= w_load_en_next;
         r_load_addr  <= w_load_addr_next;
         r_feed_en    <= w_feed_en_next;
         r_feed_addr  <= w_feed_addr_next;
         r_acc_clear  <= w_acc_clear_next;
         r_drain_en   <= w_drain_en_next;
         r_drain_addr <= w_drain_addr_next;
         r_done       <= w_done_next;
      end
   end

   assign bus.phase        = r_phase;
   assign bus.busy         = r_busy;
   assign bus.w_load_en    = r_load_en;
   assign bus.w_row_addr   = r_load_addr;
   assign bus.act_feed_en  = r_feed_en;
   assign bus.act_row_addr = r_feed_addr;
   assign bus.acc_clear    = r_acc_clear;
   assign bus.drain_en     = r_drain_en;
   assign bus.drain_row    = r_drain_addr;
   assign bus.done         = r_done;

`ifdef CTRL_SEQ_CHECK_EN
   logic [CNT_W-1:0] r_sc_prev;
   logic             r_run_prev;
   logic             r_seq_err;
   logic             w_seq_fault;

   // The first paused cycle still shows the counter's final increment, so the frozen check waits one cycle.
   always_comb begin
      w_seq_fault = (w_run && r_run_prev && (w_sc != r_sc_prev + CNT_W'(1))) ||
                    (!w_run && !r_run_prev && (r_phase != PH_DONE) && (w_sc != r_sc_prev)) ||
                    (w_run && (w_sc >= L_3N));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sc_prev  <= '0;
         r_run_prev <= 1'b0;
         r_seq_err  <= 1'b0;
      end else begin
         r_sc_prev  <= w_sc;
         r_run_prev <= w_run;
         r_seq_err  <= r_seq_err | w_seq_fault;
      end
   end

   assign bus.seq_err = r_seq_err;
`else
   assign bus.seq_err = 1'b0;
`endif

endmodule
